// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD host: command encodings, host state set,
// default frame/window geometry and the controller busy timeout.
package lcd_pkg;

  localparam int PIX_W         = 8;
  localparam int IMG_BYTES_DEF = 36;
  localparam int WIN_BYTES_DEF = 9;
  localparam int BUSY_TIMEOUT  = 64;

  typedef enum logic [2:0] {
    CMD_REFLASH = 3'd0,
    CMD_LOAD    = 3'd1,
    CMD_SHIFT_R = 3'd2,
    CMD_SHIFT_L = 3'd3,
    CMD_SHIFT_U = 3'd4,
    CMD_SHIFT_D = 3'd5
  } lcd_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_ISSUE,
    ST_LOAD,
    ST_GUARD,
    ST_WAIT_BUSY
  } host_state_e;

  // Codes 6 and 7 are reserved and never reach the controller.
  function automatic logic op_supported(input logic [2:0] op);
    return op <= 3'd5;
  endfunction

endpackage

// File: rtl/lcd_img_buf.sv
// Image staging buffer: bytes written in raster order until full, then
// streamed out through a separate read pointer; a clear empties both.
module lcd_img_buf
  import lcd_pkg::*;
#(
  parameter int DEPTH  = IMG_BYTES_DEF,
  parameter int DATA_W = PIX_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clr,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_full,
  output logic              o_wr_last,
  output logic              o_rd_done
);

  localparam int AW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic              r_full;
  logic              w_wr;

  assign w_wr      = i_wr_en && !r_full;
  assign o_full    = r_full;
  assign o_wr_last = (r_wptr == AW'(DEPTH - 1));
  assign o_rd_done = (r_rptr == AW'(DEPTH));
  assign o_rd_data = (r_rptr < AW'(DEPTH)) ? r_mem[r_rptr[IW-1:0]] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_full <= 1'b0;
    end else if (i_clr) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_full <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + 1'b1;
        if (o_wr_last)
          r_full <= 1'b1;
      end
      if (i_rd_en && !o_rd_done)
        r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[r_wptr[IW-1:0]] <= i_wr_data;
  end

endmodule

// File: rtl/lcd_host.sv
// Host sequencer between an upstream pixel/op source and an LCD controller:
// stages the frame, issues commands, streams image bytes and captures windows.
module lcd_host
  import lcd_pkg::*;
#(
  parameter int IMG_BYTES = IMG_BYTES_DEF,
  parameter int WIN_BYTES = WIN_BYTES_DEF,
  parameter int DATA_W    = PIX_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] i_pix_in,
  input  logic              i_pix_valid,
  output logic              o_pix_ready,
  input  logic [2:0]        i_op,
  input  logic              i_op_valid,
  output logic              o_op_ready,
  output logic [2:0]        o_lcd_cmd,
  output logic              o_lcd_cmd_valid,
  output logic [DATA_W-1:0] o_lcd_datain,
  input  logic              i_lcd_busy,
  input  logic [DATA_W-1:0] i_lcd_dataout,
  input  logic              i_lcd_output_valid,
  output logic [DATA_W-1:0] o_out_pix,
  output logic              o_out_valid,
  output logic              o_out_last,
  output logic              o_err
);

  host_state_e       r_state;
  lcd_cmd_e          r_op;
  logic              r_pend;
  logic              r_refl;
  logic [3:0]        r_cnt;
  logic [6:0]        r_tmo;
  logic              r_pix_ready;
  logic              r_op_ready;
  logic [2:0]        r_cmd;
  logic              r_cmd_valid;
  logic [DATA_W-1:0] r_datain;
  logic [DATA_W-1:0] r_out_pix;
  logic              r_out_valid;
  logic              r_out_last;
  logic              r_err;

  logic              w_pix_xfer;
  logic              w_op_xfer;
  logic              w_rd_en;
  logic              w_clr;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_full;
  logic              w_wr_last;
  logic              w_rd_done;
  logic              w_full_nxt;
  logic              w_cap;
  logic [3:0]        w_cnt_nxt;

  assign w_pix_xfer = i_pix_valid && r_pix_ready;
  assign w_op_xfer  = i_op_valid && r_op_ready;
  assign w_rd_en    = (r_state == ST_ISSUE && r_cmd_valid && r_op == CMD_LOAD) ||
                      (r_state == ST_LOAD && !w_rd_done);
  assign w_clr      = (r_state == ST_LOAD) && w_rd_done;
  // Full flag as it will stand after this edge, so ready outputs can be registered.
  assign w_full_nxt = !w_clr && (w_full || (w_pix_xfer && w_wr_last));
  assign w_cap      = i_lcd_output_valid && r_refl && (r_cnt != 4'(WIN_BYTES));
  assign w_cnt_nxt  = r_cnt + {3'b000, w_cap};

  lcd_img_buf #(
    .DEPTH  (IMG_BYTES),
    .DATA_W (DATA_W)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (w_clr),
    .i_wr_en   (w_pix_xfer),
    .i_wr_data (i_pix_in),
    .i_rd_en   (w_rd_en),
    .o_rd_data (w_rd_data),
    .o_full    (w_full),
    .o_wr_last (w_wr_last),
    .o_rd_done (w_rd_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_op        <= CMD_REFLASH;
      r_pend      <= 1'b0;
      r_refl      <= 1'b0;
      r_cnt       <= '0;
      r_tmo       <= '0;
      r_pix_ready <= 1'b0;
      r_op_ready  <= 1'b0;
      r_cmd       <= '0;
      r_cmd_valid <= 1'b0;
      r_datain    <= '0;
      r_out_pix   <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_cmd_valid <= 1'b0;
      r_op_ready  <= 1'b0;
      r_pix_ready <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_cnt       <= w_cnt_nxt;

      // Window bytes are only legal while a REFLASH is outstanding and not yet complete.
      if (i_lcd_output_valid) begin
        if (w_cap) begin
          r_out_pix   <= i_lcd_dataout;
          r_out_valid <= 1'b1;
          r_out_last  <= (r_cnt == 4'(WIN_BYTES - 1));
        end else begin
          r_err <= 1'b1;
        end
      end

      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_op_xfer && !op_supported(i_op))
            r_err <= 1'b1;
          if (w_op_xfer && op_supported(i_op)) begin
            r_op <= lcd_cmd_e'(i_op);
            if (i_op != CMD_LOAD || w_full_nxt) begin
              r_state <= ST_ISSUE;
            end else begin
              r_pend      <= 1'b1;
              r_state     <= ST_FILL;
              r_pix_ready <= 1'b1;
            end
          end else if (w_pix_xfer) begin
            r_pend      <= 1'b0;
            r_state     <= ST_FILL;
            r_pix_ready <= !w_full_nxt;
          end else begin
            r_op_ready  <= 1'b1;
            r_pix_ready <= !w_full_nxt;
          end
        end

        // Without a held op, FILL falls back to IDLE once the stream pauses or fills.
        ST_FILL: begin
          if (r_pend && w_full_nxt) begin
            r_pend  <= 1'b0;
            r_state <= ST_ISSUE;
          end else if (!r_pend && (!w_pix_xfer || w_full_nxt)) begin
            r_state     <= ST_IDLE;
            r_op_ready  <= 1'b1;
            r_pix_ready <= !w_full_nxt;
          end else begin
            r_pix_ready <= !w_full_nxt;
          end
        end

        ST_ISSUE: begin
          if (r_cmd_valid) begin
            r_tmo <= '0;
            if (r_op == CMD_LOAD) begin
              r_datain <= w_rd_data;
              r_state  <= ST_LOAD;
            end else begin
              r_state <= ST_GUARD;
            end
          end else if (i_lcd_busy) begin
            if (r_tmo == 7'(BUSY_TIMEOUT)) begin
              r_err       <= 1'b1;
              r_tmo       <= '0;
              r_state     <= ST_IDLE;
              r_op_ready  <= 1'b1;
              r_pix_ready <= !w_full_nxt;
            end else begin
              r_tmo <= r_tmo + 7'd1;
            end
          end else begin
            r_cmd_valid <= 1'b1;
            r_cmd       <= r_op;
            r_refl      <= (r_op == CMD_REFLASH);
            r_tmo       <= '0;
          end
        end

        ST_LOAD: begin
          if (w_rd_done)
            r_state <= ST_GUARD;
          else
            r_datain <= w_rd_data;
        end

        ST_GUARD: begin
          r_tmo   <= '0;
          r_state <= ST_WAIT_BUSY;
        end

        ST_WAIT_BUSY: begin
          if (i_lcd_busy) begin
            if (r_tmo == 7'(BUSY_TIMEOUT)) begin
              r_err       <= 1'b1;
              r_tmo       <= '0;
              r_refl      <= 1'b0;
              r_state     <= ST_IDLE;
              r_op_ready  <= 1'b1;
              r_pix_ready <= !w_full_nxt;
            end else begin
              r_tmo <= r_tmo + 7'd1;
            end
          end else begin
            if (r_refl && w_cnt_nxt != 4'(WIN_BYTES))
              r_err <= 1'b1;
            r_refl      <= 1'b0;
            r_state     <= ST_IDLE;
            r_op_ready  <= 1'b1;
            r_pix_ready <= !w_full_nxt;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_pix_ready     = r_pix_ready;
  assign o_op_ready      = r_op_ready;
  assign o_lcd_cmd       = r_cmd;
  assign o_lcd_cmd_valid = r_cmd_valid;
  assign o_lcd_datain    = r_datain;
  assign o_out_pix       = r_out_pix;
  assign o_out_valid     = r_out_valid;
  assign o_out_last      = r_out_last;
  assign o_err           = r_err;

endmodule

// File: tb/tb_lcd_host.sv
// Directed bench for lcd_host with a small LCD controller model that stores
// the loaded frame and returns 3x3 windows at a movable origin.
module tb_lcd_host;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pix_in;
  logic       pix_valid;
  logic       pix_ready;
  logic [2:0] op;
  logic       op_valid;
  logic       op_ready;
  logic [2:0] lcd_cmd;
  logic       lcd_cmd_valid;
  logic [7:0] lcd_datain;
  logic       lcd_busy;
  logic [7:0] lcd_dataout;
  logic       lcd_ov;
  logic [7:0] out_pix;
  logic       out_valid;
  logic       out_last;
  logic       err;

  always #5 clk = ~clk;

  lcd_host dut (
    .clk                (clk),
    .reset              (reset),
    .i_pix_in           (pix_in),
    .i_pix_valid        (pix_valid),
    .o_pix_ready        (pix_ready),
    .i_op               (op),
    .i_op_valid         (op_valid),
    .o_op_ready         (op_ready),
    .o_lcd_cmd          (lcd_cmd),
    .o_lcd_cmd_valid    (lcd_cmd_valid),
    .o_lcd_datain       (lcd_datain),
    .i_lcd_busy         (lcd_busy),
    .i_lcd_dataout      (lcd_dataout),
    .i_lcd_output_valid (lcd_ov),
    .o_out_pix          (out_pix),
    .o_out_valid        (out_valid),
    .o_out_last         (out_last),
    .o_err              (err)
  );

  int total = 0;
  int bad   = 0;

  int         n_cmd;
  int         last_cmd;
  int         last_idx;
  logic [7:0] win_q[$];
  logic [7:0] load_q[$];

  // Controller model: busy from the command cycle, frame capture on load,
  // window replay (m_nwin bytes) on reflash, saturating origin moves on shifts.
  int         m_mode;
  int         m_t;
  int         m_row;
  int         m_col;
  int         m_nwin;
  logic [7:0] m_img [36];

  initial begin
    lcd_busy = 1'b0; lcd_dataout = 8'd0; lcd_ov = 1'b0;
    m_mode = 0; m_t = 0; m_row = 2; m_col = 2; m_nwin = 9;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        m_mode = 0; lcd_busy = 1'b0; lcd_ov = 1'b0;
      end else if (m_mode == 0) begin
        lcd_ov = 1'b0;
        if (lcd_cmd_valid) begin
          m_t = 0; lcd_busy = 1'b1; m_mode = 3;
          case (lcd_cmd)
            3'd0: m_mode = 2;
            3'd1: m_mode = 1;
            3'd2: if (m_col < 5) m_col++;
            3'd3: if (m_col > 0) m_col--;
            3'd4: if (m_row > 0) m_row--;
            3'd5: if (m_row < 5) m_row++;
            default: m_mode = 3;
          endcase
        end
      end else begin
        m_t++;
        case (m_mode)
          1: begin
            if (m_t >= 1 && m_t <= 36) m_img[m_t-1] = lcd_datain;
            if (m_t == 40) begin lcd_busy = 1'b0; m_mode = 0; end
          end
          2: begin
            if (m_t >= 3 && m_t < 3 + m_nwin) begin
              lcd_ov = 1'b1;
              lcd_dataout = m_img[(m_row*6 + m_col + ((m_t-3)/3)*6 + (m_t-3)%3) % 36];
            end else begin
              lcd_ov = 1'b0;
            end
            if (m_t == 4 + m_nwin) begin lcd_busy = 1'b0; m_mode = 0; end
          end
          default: if (m_t == 3) begin lcd_busy = 1'b0; m_mode = 0; end
        endcase
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_pix(input int n, input int start);
    int cnt = 0;
    int guard = 0;
    while (cnt < n && guard < 500) begin
      @(negedge clk); guard++;
      if (pix_ready) begin pix_valid = 1'b1; pix_in = 8'(start + cnt); cnt++; end
      else pix_valid = 1'b0;
    end
    @(negedge clk);
    pix_valid = 1'b0;
    check("pix_accepted", cnt, n);
  endtask

  task automatic accept_op(input logic [2:0] code);
    int guard = 0;
    @(negedge clk);
    while (!op_ready && guard < 200) begin @(negedge clk); guard++; end
    check("op_ready_wait", op_ready, 1);
    op = code; op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic monitor(input int budget);
    int ncyc = 0;
    int since = -1;
    bit done = 1'b0;
    n_cmd = 0; last_cmd = -1; last_idx = -1;
    win_q.delete(); load_q.delete();
    while (!done && ncyc < budget) begin
      @(negedge clk); ncyc++;
      if (since >= 0) since++;
      if (since >= 1 && since <= 36) load_q.push_back(lcd_datain);
      if (lcd_cmd_valid) begin n_cmd++; last_cmd = int'(lcd_cmd); since = 0; end
      if (out_valid) begin
        win_q.push_back(out_pix);
        if (out_last) last_idx = win_q.size() - 1;
      end
      if (op_ready) done = 1'b1;
    end
    check("back_to_idle", done, 1);
  endtask

  logic [7:0] exp35 [9] = '{8'd14, 8'd15, 8'd16, 8'd20, 8'd21, 8'd22, 8'd26, 8'd27, 8'd28};
  int seen;
  int guard;

  initial begin
    reset = 1'b1; pix_in = 8'd0; pix_valid = 1'b0; op = 3'd0; op_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_op_ready", op_ready, 0);
    check("rst_pix_ready", pix_ready, 0);
    check("rst_cmd_valid", lcd_cmd_valid, 0);
    check("rst_err", err, 0);
    reset = 1'b0;
    #1 check("rel_op_ready_now", op_ready, 0);
    @(negedge clk);
    check("rel_op_ready_1cyc", op_ready, 1);
    check("rel_pix_ready", pix_ready, 1);

    // Full frame load
    push_pix(36, 0);
    check("full_pix_ready", pix_ready, 0);
    accept_op(3'd1);
    monitor(200);
    check("load_ncmd", n_cmd, 1);
    check("load_cmd", last_cmd, 1);
    check("load_len", load_q.size(), 36);
    for (int k = 0; k < 36 && k < load_q.size(); k++) check("load_byte", load_q[k], k);
    check("load_err", err, 0);

    // Reflash at origin (2,2)
    accept_op(3'd0);
    monitor(100);
    check("win0_len", win_q.size(), 9);
    for (int k = 0; k < 9 && k < win_q.size(); k++) check("win0_byte", win_q[k], exp35[k]);
    check("win0_last", last_idx, 8);
    check("win0_err", err, 0);

    // Five right shifts; column saturates
    for (int i = 0; i < 5; i++) begin
      accept_op(3'd2);
      monitor(50);
      check("shr_ncmd", n_cmd, 1);
      check("shr_cmd", last_cmd, 2);
    end
    accept_op(3'd0);
    monitor(100);
    check("win1_len", win_q.size(), 9);
    if (win_q.size() > 0) check("win1_first", win_q[0], 17);
    check("win1_last", last_idx, 8);
    check("win1_err", err, 0);

    // Load requested with only 20 bytes staged
    push_pix(20, 0);
    accept_op(3'd1);
    seen = 0;
    repeat (5) begin @(negedge clk); if (lcd_cmd_valid) seen++; end
    check("part_no_cmd", seen, 0);
    check("part_pix_ready", pix_ready, 1);
    push_pix(16, 20);
    check("part_full_ready", pix_ready, 0);
    check("part_cmd_not_yet", lcd_cmd_valid, 0);
    monitor(200);
    check("part_ncmd", n_cmd, 1);
    check("part_cmd", last_cmd, 1);
    check("part_len", load_q.size(), 36);
    if (load_q.size() == 36) begin
      check("part_b0", load_q[0], 0);
      check("part_b20", load_q[20], 20);
      check("part_b35", load_q[35], 35);
    end
    check("part_err", err, 0);

    // Short window: controller drops busy after 8 bytes
    m_nwin = 8;
    accept_op(3'd0);
    monitor(100);
    m_nwin = 9;
    check("short_len", win_q.size(), 8);
    check("short_err", err, 1);
    accept_op(3'd3);
    monitor(50);
    check("short_shl_ncmd", n_cmd, 1);
    check("short_err_sticky", err, 1);

    // Reset in the middle of a frame load
    push_pix(36, 0);
    accept_op(3'd1);
    guard = 0;
    while (!lcd_cmd_valid && guard < 20) begin @(negedge clk); guard++; end
    check("mid_cmd_seen", lcd_cmd_valid, 1);
    repeat (10) @(negedge clk);
    check("mid_datain", lcd_datain, 9);
    reset = 1'b1;
    #1;
    check("mid_rst_cmd_valid", lcd_cmd_valid, 0);
    check("mid_rst_cmd", lcd_cmd, 0);
    check("mid_rst_datain", lcd_datain, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_last", out_last, 0);
    check("mid_rst_out_pix", out_pix, 0);
    check("mid_rst_pix_ready", pix_ready, 0);
    check("mid_rst_op_ready", op_ready, 0);
    check("mid_rst_err", err, 0);
    seen = 0;
    repeat (2) begin @(negedge clk); if (lcd_cmd_valid) seen++; end
    reset = 1'b0;
    #1 check("mid_rel_op_ready_now", op_ready, 0);
    @(negedge clk);
    check("mid_rel_op_ready", op_ready, 1);
    repeat (10) begin @(negedge clk); if (lcd_cmd_valid) seen++; end
    check("mid_no_cmd", seen, 0);

    // Reserved op
    accept_op(3'd6);
    monitor(20);
    check("rsv_ncmd", n_cmd, 0);
    check("rsv_err", err, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
